// File: rtl/uart_tx_top.sv
// UART transmitter: AXI-Stream slave into a circular FIFO, serialized as
// start / D_W data bits LSB-first / stop, one bit per B_TICK baud ticks.
module uart_tx_top #(
  parameter int unsigned D_W    = 8,
  parameter int unsigned B_TICK = 16,
  parameter int unsigned DEPTH  = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           b_clk,
  output logic           b_en,
  input  logic [D_W-1:0] s_axis_data,
  input  logic           s_axis_tvalid,
  output logic           s_axis_tready,
  output logic           tx_data,
  output logic           busy,
  output logic           ff_empty,
  output logic           ff_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (B_TICK > 1) ? $clog2(B_TICK) : 1;
  localparam int unsigned BW = (D_W > 1) ? $clog2(D_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic            r_tx;
  logic            r_busy;
  logic [TW-1:0]   r_tick;
  logic [BW-1:0]   r_bit;
  logic [D_W-1:0]  r_shift;
  logic [D_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_tick_end;
  logic [D_W-1:0]  w_head;
  logic [D_W-1:0]  w_shift_nxt;

  assign ff_empty      = (r_count == CW'(0));
  assign ff_full       = (r_count == CW'(DEPTH));
  assign s_axis_tready = !ff_full;
  assign tx_data       = r_tx;
  assign busy          = r_busy;
  assign b_en          = r_busy;

  // Pop happens only from IDLE; push uses the pre-cycle full flag, so a pop at full never admits a push.
  assign w_push      = s_axis_tvalid && !ff_full;
  assign w_pop       = (r_state == S_IDLE) && !ff_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_tick_end  = b_clk && (r_tick == TW'(B_TICK - 1));
  assign w_shift_nxt = r_shift >> 1;

  // Storage array carries no reset; occupancy is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_axis_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Frame sequencer; the tick counter runs only while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if ((r_state != S_IDLE) && b_clk) begin
        r_tick <= w_tick_end ? TW'(0) : r_tick + TW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (!ff_empty) begin
            r_shift <= w_head;
            r_tick  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick_end) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick_end) begin
            r_shift <= w_shift_nxt;
            if (r_bit == BW'(D_W - 1)) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx  <= w_shift_nxt[0];
              r_bit <= r_bit + BW'(1);
            end
          end
        end
        S_STOP: begin
          if (w_tick_end) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: tick-level frame/FIFO model compared every cycle,
// a mid-bit line decoder, and directed scenarios with literal expectations.
module tb_uart_tx_top;
  localparam int D_W    = 8;
  localparam int B_TICK = 16;
  localparam int DEPTH  = 64;
  localparam int FRAME  = (D_W + 2) * B_TICK;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           b_clk = 1'b0;
  logic           b_en;
  logic [D_W-1:0] s_axis_data = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           tx_data;
  logic           busy;
  logic           ff_empty;
  logic           ff_full;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic bclk_en = 1'b0;
  int   bclk_div = 1;

  logic           lit_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [D_W-1:0] b2b [3] = '{8'h00, 8'hFF, 8'h55};

  uart_tx_top #(.D_W(D_W), .B_TICK(B_TICK), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .b_clk(b_clk), .b_en(b_en),
    .s_axis_data(s_axis_data), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .tx_data(tx_data), .busy(busy), .ff_empty(ff_empty), .ff_full(ff_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    b_clk = bclk_en && ((cyc % bclk_div) == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of accepted bytes plus ticks elapsed in the current frame.
  logic [D_W-1:0] mq [$];
  logic [D_W-1:0] m_cur = '0;
  bit             m_in = 1'b0;
  bit             m_valid = 1'b0;
  bit             m_push;
  int             m_t = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_in = 1'b0;
      m_t = 0;
      m_valid = 1'b1;
    end else begin
      m_push = s_axis_tvalid && (mq.size() < DEPTH);
      if (!m_in && mq.size() != 0) begin
        m_cur = mq.pop_front();
        m_in = 1'b1;
        m_t = 0;
      end else if (m_in && b_clk) begin
        m_t++;
        if (m_t == FRAME) m_in = 1'b0;
      end
      if (m_push) mq.push_back(s_axis_data);
    end
  end

  function automatic logic m_line();
    int seg;
    if (!m_in) return 1'b1;
    seg = m_t / B_TICK;
    if (seg == 0) return 1'b0;
    if (seg <= D_W) return m_cur[seg-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (m_valid)
      check("model_cycle {tx,busy,b_en,empty,full,tready}",
            {26'd0, tx_data, busy, b_en, ff_empty, ff_full, s_axis_tready},
            {26'd0, m_line(), m_in, m_in, mq.size() == 0, mq.size() == DEPTH, mq.size() != DEPTH});
  end

  // Line decoder: samples the middle tick of each bit period while busy.
  logic [D_W-1:0] exp_rx [$];
  logic [D_W-1:0] d_byte = '0;
  int             d_n = 0;

  always @(negedge clk) begin
    if (rst || !busy) begin
      d_n = 0;
    end else if (b_clk) begin
      d_n++;
      if ((d_n % B_TICK) == B_TICK / 2) begin
        if (d_n / B_TICK == 0)        check("rx_start_bit", {31'd0, tx_data}, 32'd0);
        else if (d_n / B_TICK <= D_W) d_byte[d_n / B_TICK - 1] = tx_data;
        else                          check("rx_stop_bit", {31'd0, tx_data}, 32'd1);
      end
      if (d_n == FRAME) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: actual byte %02h required none", d_byte);
        end else begin
          check("rx_byte", {24'd0, d_byte}, {24'd0, exp_rx.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [D_W-1:0] d);
    tick();
    s_axis_tvalid = 1'b1;
    s_axis_data = d;
    exp_rx.push_back(d);
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int limit, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy !== val) begin
      checks++;
      errors++;
      $display("FAIL %s: actual busy=%0b required %0b within %0d cycles", name, busy, val, limit);
    end
  endtask

  task automatic wait_rx_done(input int limit, input string name);
    int n;
    n = 0;
    while (exp_rx.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_rx.size(), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int st;
    int off;
    int n;
    int gap;

    repeat (3) tick();
    @(negedge clk);
    check("reset_outs {tx,busy,b_en,empty,full,tready}",
          {26'd0, tx_data, busy, b_en, ff_empty, ff_full, s_axis_tready}, 32'b100101);
    tick();
    rst = 1'b0;

    // Single byte, tick every 4th clk, push phased so each bit spans 64 clk.
    bclk_div = 4;
    bclk_en = 1'b1;
    do tick(); while (cyc % 4 != 3);
    s_axis_tvalid = 1'b1;
    s_axis_data = 8'hA5;
    exp_rx.push_back(8'hA5);
    tick();
    s_axis_tvalid = 1'b0;
    wait_busy(1'b1, 10, "a5_start");
    st = cyc;
    check("a5_b_en", {31'd0, b_en}, 32'd1);
    off = 0;
    for (int i = 0; i < 10; i++) begin
      repeat (32 + 64 * i - off) @(negedge clk);
      off = 32 + 64 * i;
      check("a5_bit", {31'd0, tx_data}, {31'd0, lit_a5[i]});
    end
    wait_busy(1'b0, 700, "a5_end");
    check("a5_busy_len", cyc - st, 32'd640);
    check("a5_empty_after", {31'd0, ff_empty}, 32'd1);
    wait_rx_done(100, "a5_rx_done");

    // Back-to-back frames separated by one idle clk.
    bclk_div = 1;
    foreach (b2b[i]) begin
      tick();
      s_axis_tvalid = 1'b1;
      s_axis_data = b2b[i];
      exp_rx.push_back(b2b[i]);
    end
    tick();
    s_axis_tvalid = 1'b0;
    wait_busy(1'b1, 10, "b2b_start");
    for (int g = 0; g < 2; g++) begin
      wait_busy(1'b0, FRAME + 10, "b2b_end");
      check("b2b_gap_line", {31'd0, tx_data}, 32'd1);
      gap = 0;
      while (busy !== 1'b1 && gap < 10) begin
        gap++;
        @(negedge clk);
      end
      check("b2b_gap_len", gap, 32'd1);
    end
    wait_rx_done(2 * FRAME, "b2b_rx_done");

    // Full FIFO: one byte held in a stalled frame, then 64 fill the FIFO.
    bclk_en = 1'b0;
    push1(8'h80);
    repeat (4) tick();
    @(negedge clk);
    check("full_stalled_start {busy,tx,empty}", {29'd0, busy, tx_data, ff_empty}, 32'b101);
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      s_axis_tvalid = 1'b1;
      s_axis_data = 8'(k * 7 + 3);
      exp_rx.push_back(8'(k * 7 + 3));
    end
    tick();
    s_axis_data = 8'hC3;
    @(negedge clk);
    check("full_flag {full,tready}", {30'd0, ff_full, s_axis_tready}, 32'b10);
    repeat (5) tick();
    @(negedge clk);
    check("full_hold {full,tready}", {30'd0, ff_full, s_axis_tready}, 32'b10);
    tick();
    bclk_en = 1'b1;
    n = 0;
    while (s_axis_tready !== 1'b1 && n < FRAME + 20) begin
      tick();
      n++;
    end
    check("full_late_accept", {31'd0, s_axis_tready}, 32'd1);
    exp_rx.push_back(8'hC3);
    tick();
    s_axis_tvalid = 1'b0;
    wait_rx_done((DEPTH + 2) * (FRAME + 2) + 100, "full_rx_done");

    // Push lands in the same cycle as the pop of a single queued byte.
    tick();
    s_axis_tvalid = 1'b1;
    s_axis_data = 8'h11;
    exp_rx.push_back(8'h11);
    tick();
    s_axis_data = 8'h22;
    exp_rx.push_back(8'h22);
    tick();
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("simul_count_one {busy,empty}", {30'd0, busy, ff_empty}, 32'b10);
    wait_rx_done(3 * FRAME, "simul_rx_done");

    // Reset during data bit 3 of 0x3C with five more bytes queued.
    tick();
    s_axis_tvalid = 1'b1;
    s_axis_data = 8'h3C;
    for (int k = 1; k <= 5; k++) begin
      tick();
      s_axis_data = 8'(k);
    end
    tick();
    s_axis_tvalid = 1'b0;
    n = 0;
    while (d_n < 4 * B_TICK + 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_bit3", {31'd0, tx_data}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outs {tx,busy,empty}", {29'd0, tx_data, busy, ff_empty}, 32'b101);
    n = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_data !== 1'b1) n++;
    end
    check("rst_mid_silent", n, 32'd0);

    // Tick stall inside data bit 3 of 0x96 (bit value 0).
    push1(8'h96);
    n = 0;
    while (d_n < 4 * B_TICK + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tick();
    bclk_en = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_data !== 1'b0 || busy !== 1'b1) n++;
    end
    check("stall_hold", n, 32'd0);
    tick();
    bclk_en = 1'b1;
    wait_rx_done(FRAME + 50, "stall_rx_done");

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
